conv2d_stream: RTL
==================

// Module: conv2d_stream
// PURPOSE
//  Streaming 3x3 convolution engine; next generation of the fixed-kernel conv stage.
//  Accepts one raster-order pixel per cycle and outputs one signed result per fully-inside window.
//  Adds parametrised widths and frame size, runtime-loadable weights and bias,
//  valid/ready backpressure on both sides, and an end-of-frame marker.
//  Sits between the pixel source and the pooling/activation stages of the CNN datapath.
// PARAMETERS
//  IMG_WIDTH   5   pixels per row (>=3)
//  IMG_HEIGHT  5   rows per frame (>=3)
//  DATA_W      8   unsigned pixel width
//  WT_W        8   signed weight/bias width
//  ACC_W       32  signed output width; must be >= DATA_W+WT_W+5
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  pix_valid  in   1       pixel present
//  pix_data   in   DATA_W  pixel, raster order
//  pix_ready  out  1       engine can accept a pixel this cycle
//  wt_we      in   1       weight/bias shadow write strobe
//  wt_addr    in   4       0..8 = kernel taps (row-major, 0 = top-left); 9 = bias; 10..15 ignored
//  wt_data    in   WT_W    signed value to write
//  out_valid  out  1       result present
//  out_data   out  ACC_W   signed convolution result
//  out_last   out  1       marks the final result of a frame
//  out_ready  in   1       sink accepts the result
// BEHAVIOUR
//  - Reset (rst=0, async): pix_ready=0, out_valid=0, out_data=0, out_last=0.
//    Reset also clears counters, pipeline stages, and both active and shadow weights/bias.
//    pix_ready rises on the first clk edge after rst deasserts.
//  - Handshake and stall:
//    - stall = out_valid & ~out_ready; pix_ready = ~stall (registered in reset only).
//    - A pixel is accepted on an edge where pix_valid & pix_ready.
//    - During stall every pipeline stage, counter and line buffer holds its value.
//    - out_data and out_last are stable while out_valid & ~out_ready.
//  - Storage: two IMG_WIDTH-deep line buffers plus a 3x3 window register.
//    All of them shift only on accept.
//  - Counters: col 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1 advance on accept.
//    col wraps to 0 and increments row; after (W-1,H-1) both wrap to 0 and a new frame begins.
//  - Window validity: a window is valid when the accepted pixel has row>=2 and col>=2.
//    This gives (W-2)*(H-2) results per frame; no padding, no cross-row windows.
//  - Pipeline: 2 stages.
//    - E0: accept edge; the window is updated.
//    - E1: nine products registered.
//    - E2: sum + bias registered into out_data; out_valid=1.
//    - Latency is 2 accepting-free edges after E0, i.e. 2 cycles without stall.
//    - Continuous flow with out_ready=1 sustains 1 result/cycle.
//  - Arithmetic:
//    - Each product = $signed({1'b0,pix}) * wt.
//    - Products sign-extend to ACC_W and are summed with the sign-extended bias.
//    - The result wraps modulo 2^ACC_W (no saturation).
//  - out_last=1 with the result whose window was completed at (W-1,H-1); it is 0 otherwise.
//  - Weights:
//    - wt_we writes the shadow register file in any cycle, independent of stall.
//    - Shadow copies to active on the accept of pixel (0,0), i.e. at frame start.
//    - A write in that same cycle is included in the copy.
//    - Writes mid-frame never affect the current frame.
//    - Before the first frame, active = shadow copy taken at the first (0,0) accept.
//  - Reset mid-frame: results in flight are discarded and counters return to (0,0).
//    The next accepted pixel is treated as (0,0) of a new frame.
//  - Line buffer contents are not cleared between frames; stale data never reaches a valid window.
// CONFIGURATION
//  CONV_RELU_EN defined:
//    - out_data = (sum<0) ? 0 : sum, applied in stage E2; no latency change.
//    - out_last and the handshake are unaffected.
//  CONV_RELU_EN undefined: out_data is the raw signed sum.
// TESTING (W=H=5, DATA_W=8, WT_W=8, ACC_W=32)
//  1. Sobel-X (1,0,-1 each row), bias 0, pixel = col*10, out_ready=1.
//     Expect 9 results, each -60, out_last on 9th only, first out_valid 2 cycles after pixel (2,2).
//  2. Same as test 1 with bias=5.
//     Expect all results -55; with CONV_RELU_EN defined, all results 0.
//  3. Test 1 with out_ready toggled 1010...
//     Expect pix_ready=0 exactly in stall cycles, out_data held while stalled,
//     and the 9 values unchanged and in order.
//  4. Write all taps=1 during frame A at pixel (3,1); run frames A then B back-to-back, pixel=1.
//     Expect frame A results = 0 (taps reset to 0) and frame B results = 9.
//  5. Assert rst=0 for 1 cycle after pixel (2,3).
//     Expect out_valid=0 immediately; the next 25 pixels form a full frame with 9 results.
//  6. Image all 255, taps all -128, bias -128.
//     Expect each result -293888 (checks sign/width handling); with CONV_RELU_EN defined, 0.

Source files
------------

// File: rtl/conv2d_stream.sv
// Streaming 3x3 convolution with loadable weights/bias and valid/ready flow control.
// Optional CONV_RELU_EN clamps negative results to zero in the output stage.
module conv2d_stream #(
    parameter int IMG_WIDTH  = 5,
    parameter int IMG_HEIGHT = 5,
    parameter int DATA_W     = 8,
    parameter int WT_W       = 8,
    parameter int ACC_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    input  logic              wt_we,
    input  logic [3:0]        wt_addr,
    input  logic [WT_W-1:0]   wt_data,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    input  logic              out_ready
);
    localparam int PW = DATA_W + WT_W + 1;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

    logic                    run_reg;
    logic [CW-1:0]           col_reg;
    logic [RW-1:0]           row_reg;
    logic [DATA_W-1:0]       lb1_mem [IMG_WIDTH];
    logic [DATA_W-1:0]       lb2_mem [IMG_WIDTH];
    logic [DATA_W-1:0]       col_in  [3];
    logic [DATA_W-1:0]       win_reg [9];
    logic signed [WT_W-1:0]  shadow_reg [10];
    logic signed [WT_W-1:0]  active_reg [10];
    logic signed [PW-1:0]    prod_c   [9];
    logic signed [PW-1:0]    prod_reg [9];
    logic signed [WT_W-1:0]  bias_reg;
    logic                    v0_reg, v1_reg, last0_reg, last1_reg;
    logic                    out_valid_reg, out_last_reg;
    logic [ACC_W-1:0]        out_data_reg;
    logic signed [ACC_W-1:0] sum_c;
    logic [ACC_W-1:0]        result_c;
    logic                    stall, adv, accept, frame_start;

    assign stall       = out_valid_reg & ~out_ready;
    assign adv         = ~stall;
    assign pix_ready   = run_reg & ~stall;
    assign accept      = pix_valid & pix_ready;
    assign frame_start = accept && (col_reg == '0) && (row_reg == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_reg <= 1'b0;
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            run_reg <= 1'b1;
            if (accept) begin
                if (col_reg == COL_MAX) begin
                    col_reg <= '0;
                    row_reg <= (row_reg == ROW_MAX) ? '0 : row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
        end
    end

    // Line buffers hold the two previous rows; stale contents only feed windows the valid flag rejects.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[col_reg] <= pix_data;
            lb2_mem[col_reg] <= lb1_mem[col_reg];
        end
    end

    assign col_in[0] = lb2_mem[col_reg];
    assign col_in[1] = lb1_mem[col_reg];
    assign col_in[2] = pix_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) win_reg[i] <= '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_reg[r*3]   <= win_reg[r*3+1];
                win_reg[r*3+1] <= win_reg[r*3+2];
                win_reg[r*3+2] <= col_in[r];
            end
        end
    end

    // A write landing on the frame-start accept must reach the active set immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 10; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
        end else begin
            if (wt_we && wt_addr <= 4'd9)
                shadow_reg[wt_addr] <= wt_data;
            if (frame_start)
                for (int i = 0; i < 10; i++)
                    active_reg[i] <= (wt_we && wt_addr == 4'(i)) ? wt_data : shadow_reg[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_tap
            assign prod_c[gi] = PW'($signed({1'b0, win_reg[gi]})) * PW'(active_reg[gi]);
        end
    endgenerate

    // Bias travels with the products so a frame-start weight swap cannot touch the previous frame's tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0_reg        <= 1'b0;
            last0_reg     <= 1'b0;
            v1_reg        <= 1'b0;
            last1_reg     <= 1'b0;
            bias_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
            for (int i = 0; i < 9; i++) prod_reg[i] <= '0;
        end else if (adv) begin
            v0_reg        <= accept && (row_reg >= RW'(2)) && (col_reg >= CW'(2));
            last0_reg     <= accept && (row_reg == ROW_MAX) && (col_reg == COL_MAX);
            v1_reg        <= v0_reg;
            last1_reg     <= last0_reg;
            bias_reg      <= active_reg[9];
            for (int i = 0; i < 9; i++) prod_reg[i] <= prod_c[i];
            out_valid_reg <= v1_reg;
            out_last_reg  <= v1_reg & last1_reg;
            out_data_reg  <= result_c;
        end
    end

    always_comb begin
        sum_c = ACC_W'(bias_reg);
        for (int i = 0; i < 9; i++) sum_c = sum_c + ACC_W'(prod_reg[i]);
    end

`ifdef CONV_RELU_EN
    assign result_c = sum_c[ACC_W-1] ? '0 : sum_c;
`else
    assign result_c = sum_c;
`endif

    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_data  = out_data_reg;
endmodule
